// File: rtl/barrel_pkg.sv
// Shared mode encodings for the pipelined barrel shifter.
// Consumed by barrel_stage and barrel_shifter_pipe.
package barrel_pkg;

   localparam int unsigned MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_ROR = 2'b00,
      MODE_ROL = 2'b01,
      MODE_SHR = 2'b10,
      MODE_SHL = 2'b11
   } mode_e;

endpackage

// File: rtl/barrel_stage.sv
// One pipeline stage: conditionally moves the word by 2^K and registers it with its control.
// BARREL_SHIFTER_SRA_EN adds the arith flag flop and sign-filled SHR.
module barrel_stage
   import barrel_pkg::*;
#(
   parameter int unsigned W = 32,
   parameter int unsigned S = $clog2(W),
   parameter int unsigned K = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   input  logic [S-1:0] amt_i,
   input  mode_e        mode_i,
`ifdef BARREL_SHIFTER_SRA_EN
   input  logic         arith_i,
   output logic         arith_o,
`endif
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic [S-1:0] amt_o,
   output mode_e        mode_o
);

   localparam int unsigned M = 1 << K;
   // Bits vacated at the top by a right shift of M.
   localparam logic [W-1:0] FILL_MASK = ~({W{1'b1}} >> M);

   logic         valid_q;
   logic [W-1:0] data_q;
   logic [W-1:0] data_d;
   logic [W-1:0] moved;
   logic [S-1:0] amt_q;
   mode_e        mode_q;
   logic         sign_fill;

`ifdef BARREL_SHIFTER_SRA_EN
   logic arith_q;
   // An arithmetic SHR keeps the MSB equal to the sign, so each stage refills from it.
   assign sign_fill = arith_i & data_i[W-1];
`else
   assign sign_fill = 1'b0;
`endif

   // Move by 2^K according to mode; pass through when amt bit K is clear.
   always_comb begin
      moved  = data_i;
      data_d = data_i;
      unique case (mode_i)
         MODE_ROR: moved = (data_i >> M) | (data_i << (W - M));
         MODE_ROL: moved = (data_i << M) | (data_i >> (W - M));
         MODE_SHR: moved = (data_i >> M) | (FILL_MASK & {W{sign_fill}});
         MODE_SHL: moved = data_i << M;
      endcase
      if (amt_i[K]) begin
         data_d = moved;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         amt_q   <= '0;
         mode_q  <= MODE_ROR;
`ifdef BARREL_SHIFTER_SRA_EN
         arith_q <= 1'b0;
`endif
      end else if (en_i) begin
         valid_q <= valid_i;
         data_q  <= data_d;
         amt_q   <= amt_i;
         mode_q  <= mode_i;
`ifdef BARREL_SHIFTER_SRA_EN
         arith_q <= arith_i;
`endif
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign amt_o   = amt_q;
   assign mode_o  = mode_q;
`ifdef BARREL_SHIFTER_SRA_EN
   assign arith_o = arith_q;
`endif

endmodule

// File: rtl/barrel_shifter_pipe.sv
// S-stage pipelined rotate/shift unit with valid/ready flow control and a global stall.
// Define BARREL_SHIFTER_SRA_EN to honour in_arith (sign-filled SHR); otherwise SHR zero-fills.
module barrel_shifter_pipe
   import barrel_pkg::*;
#(
   parameter int unsigned W = 32,
   localparam int unsigned S = $clog2(W)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic [S-1:0] in_amt,
   input  logic [1:0]   in_mode,
   input  logic         in_arith,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   // Index 0 is the input side, index S the output of the last stage.
   logic         valid_s [S+1];
   logic [W-1:0] data_s  [S+1];
   logic [S-1:0] amt_s   [S+1];
   mode_e        mode_s  [S+1];
   logic         stall_c;
   logic         en_c;
   logic         unused_tail;

   assign stall_c = out_valid & ~out_ready;
   assign en_c    = ~stall_c;
   assign in_ready = en_c;

   assign valid_s[0] = in_valid;
   assign data_s[0]  = in_data;
   assign amt_s[0]   = in_amt;
   assign mode_s[0]  = mode_e'(in_mode);

`ifdef BARREL_SHIFTER_SRA_EN
   logic arith_s [S+1];
   assign arith_s[0]  = in_arith;
   assign unused_tail = ^{amt_s[S], mode_s[S], arith_s[S]};
`else
   assign unused_tail = ^{amt_s[S], mode_s[S], in_arith};
`endif

   for (genvar k = 0; k < S; k++) begin : g_stage
      barrel_stage #(
         .W (W),
         .S (S),
         .K (k)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .en_i    (en_c),
         .valid_i (valid_s[k]),
         .data_i  (data_s[k]),
         .amt_i   (amt_s[k]),
         .mode_i  (mode_s[k]),
`ifdef BARREL_SHIFTER_SRA_EN
         .arith_i (arith_s[k]),
         .arith_o (arith_s[k+1]),
`endif
         .valid_o (valid_s[k+1]),
         .data_o  (data_s[k+1]),
         .amt_o   (amt_s[k+1]),
         .mode_o  (mode_s[k+1])
      );
   end

   assign out_valid = valid_s[S];
   assign out_data  = data_s[S];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed self-checking bench for barrel_shifter_pipe at W=32.
module tb_barrel_shifter_pipe;

   localparam int unsigned W = 32;
   localparam int unsigned S = 5;
`ifdef BARREL_SHIFTER_SRA_EN
   localparam bit SRA = 1'b1;
`else
   localparam bit SRA = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [S-1:0]  in_amt;
   logic [1:0]    in_mode;
   logic          in_arith;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   barrel_shifter_pipe #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_mode   (in_mode),
      .in_arith  (in_arith),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   // Bit-at-a-time reference model.
   function automatic logic [31:0] model(input logic [31:0] d, input int a,
                                         input logic [1:0] m, input logic ar);
      logic [31:0] r;
      r = d;
      for (int i = 0; i < a; i++) begin
         case (m)
            2'b00:   r = {r[0], r[31:1]};
            2'b01:   r = {r[30:0], r[31]};
            2'b10:   r = {(SRA && ar) ? r[31] : 1'b0, r[31:1]};
            default: r = {r[30:0], 1'b0};
         endcase
      end
      return r;
   endfunction

   task automatic idle_inputs();
      in_valid = 1'b0;
      in_data  = '0;
      in_amt   = '0;
      in_mode  = 2'b00;
      in_arith = 1'b0;
   endtask

   // Drives one word into an empty pipe and reports its result and latency.
   task automatic run_single(input logic [31:0] d, input logic [4:0] a, input logic [1:0] m,
                             input logic ar, output logic [31:0] got, output int lat);
      in_valid  = 1'b1;
      in_data   = d;
      in_amt    = a;
      in_mode   = m;
      in_arith  = ar;
      out_ready = 1'b1;
      @(negedge clk);
      idle_inputs();
      lat = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      got = out_data;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'hDEADBEEF;
      in_amt    = 5'd3;
      in_mode   = 2'b01;
      in_arith  = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (out_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_out_data: got %h expected 00000000", out_data);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      rst = 1'b0;
      idle_inputs();
      repeat (S + 1) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_valid: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_rotate();
      logic [31:0] td [8];
      logic [4:0]  ta [8];
      logic [1:0]  tm [8];
      logic [31:0] te [8];
      logic [31:0] got;
      int          lat;
      td = '{32'hFFFF0000, 32'hFFFF0000, 32'h80000001, 32'h12345678,
             32'h12345678, 32'h12345678, 32'h12345678, 32'h00000001};
      ta = '{5'd4, 5'd16, 5'd1, 5'd0, 5'd8, 5'd24, 5'd8, 5'd31};
      tm = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
      te = '{32'h0FFFF000, 32'h0000FFFF, 32'h00000003, 32'h12345678,
             32'h78123456, 32'h78123456, 32'h34567812, 32'h00000002};
      for (int i = 0; i < 8; i++) begin
         run_single(td[i], ta[i], tm[i], 1'b0, got, lat);
         checks++;
         if (lat != S) begin
            failures++;
            $display("FAIL rotate_latency[%0d]: got %0d expected %0d", i, lat, S);
         end
         checks++;
         if (got !== te[i]) begin
            failures++;
            $display("FAIL rotate_data[%0d]: got %h expected %h", i, got, te[i]);
         end
      end
   endtask

   task automatic test_shift();
      logic [31:0] td [7];
      logic [4:0]  ta [7];
      logic [1:0]  tm [7];
      logic        tr [7];
      logic [31:0] te [7];
      logic [31:0] got;
      int          lat;
      td = '{32'h80000000, 32'h00000001, 32'hF0000000, 32'hF0000000,
             32'h40000000, 32'hFFFFFFFF, 32'hA5A5A5A5};
      ta = '{5'd31, 5'd31, 5'd4, 5'd4, 5'd4, 5'd8, 5'd0};
      tm = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
      tr = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      te = '{SRA ? 32'hFFFFFFFF : 32'h00000001, 32'h80000000, 32'h0F000000,
             SRA ? 32'hFF000000 : 32'h0F000000, 32'h04000000, 32'hFFFFFF00, 32'hA5A5A5A5};
      for (int i = 0; i < 7; i++) begin
         run_single(td[i], ta[i], tm[i], tr[i], got, lat);
         checks++;
         if (lat != S || got !== te[i]) begin
            failures++;
            $display("FAIL shift[%0d]: got %h after %0d cycles expected %h after %0d",
                     i, got, lat, te[i], S);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_q [$];
      logic [31:0] held;
      logic [31:0] d;
      logic [4:0]  a;
      logic [1:0]  m;
      logic        ar;
      logic        exp_rdy;
      int          sent = 0;
      int          rcvd = 0;
      for (int c = 0; c < 40 && rcvd < 8; c++) begin
         @(negedge clk);
         out_ready = !(c >= 7 && c <= 9);
         #1;
         if (c <= 12) begin
            exp_rdy = !(c >= 7 && c <= 9);
            checks++;
            if (in_ready !== exp_rdy) begin
               failures++;
               $display("FAIL bp_in_ready[c%0d]: got %b expected %b", c, in_ready, exp_rdy);
            end
         end
         if (c == 7) held = out_data;
         if (c == 8 || c == 9) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== held) begin
               failures++;
               $display("FAIL bp_hold[c%0d]: got valid=%b data=%h expected valid=1 data=%h",
                        c, out_valid, out_data, held);
            end
         end
         if (out_valid === 1'b1 && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL bp_extra: got %h expected no word", out_data);
            end else begin
               if (out_data !== exp_q[0]) begin
                  failures++;
                  $display("FAIL bp_order[%0d]: got %h expected %h", rcvd, out_data, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
            rcvd++;
         end
         if (sent < 8) begin
            d  = 32'h13579BDF ^ (32'h01010101 << sent);
            a  = 5'(3 * sent + 1);
            m  = 2'(sent);
            ar = sent[0];
            in_valid = 1'b1;
            in_data  = d;
            in_amt   = a;
            in_mode  = m;
            in_arith = ar;
            if (in_ready === 1'b1) begin
               exp_q.push_back(model(d, int'(a), m, ar));
               sent++;
            end
         end else begin
            idle_inputs();
         end
      end
      idle_inputs();
      out_ready = 1'b1;
      checks++;
      if (rcvd != 8 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL bp_count: got %0d results expected 8", rcvd);
      end
      repeat (S + 2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_duplicate: got out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_sweep();
      logic [31:0] sd [128];
      logic        sr [128];
      logic [31:0] exp_q [$];
      int          sent = 0;
      int          rcvd = 0;
      int          first_rx = -1;
      int          last_rx = -1;
      int          rdy_bad = 0;
      for (int i = 0; i < 128; i++) begin
         sd[i] = $urandom;
         sr[i] = 1'($urandom_range(0, 1));
      end
      out_ready = 1'b1;
      for (int c = 0; c < 200 && rcvd < 128; c++) begin
         @(negedge clk);
         if (in_ready !== 1'b1) rdy_bad++;
         if (out_valid === 1'b1) begin
            if (first_rx < 0) first_rx = c;
            last_rx = c;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL sweep_extra: got %h expected no word", out_data);
            end else begin
               if (out_data !== exp_q[0]) begin
                  failures++;
                  $display("FAIL sweep[%0d]: got %h expected %h", rcvd, out_data, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
            rcvd++;
         end
         if (sent < 128) begin
            in_valid = 1'b1;
            in_data  = sd[sent];
            in_amt   = 5'(sent % 32);
            in_mode  = 2'(sent / 32);
            in_arith = sr[sent];
            if (in_ready === 1'b1) begin
               exp_q.push_back(model(sd[sent], sent % 32, 2'(sent / 32), sr[sent]));
               sent++;
            end
         end else begin
            idle_inputs();
         end
      end
      idle_inputs();
      checks++;
      if (rcvd != 128 || first_rx != S || last_rx != 127 + S || rdy_bad != 0) begin
         failures++;
         $display("FAIL sweep_throughput: got %0d words cycles %0d..%0d ready_drops=%0d expected 128 words cycles %0d..%0d ready_drops=0",
                  rcvd, first_rx, last_rx, rdy_bad, S, 127 + S);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [31:0] got;
      int          lat;
      int          stale = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h0F0F0F0F + 32'(i);
         in_amt   = 5'(i + 1);
         in_mode  = 2'b00;
         in_arith = 1'b0;
         @(negedge clk);
      end
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midrst_state: got in_ready=%b out_valid=%b expected 1 and 0",
                  in_ready, out_valid);
      end
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid !== 1'b0) stale++;
         @(negedge clk);
      end
      checks++;
      if (stale != 0) begin
         failures++;
         $display("FAIL midrst_stale: got %0d stale valid cycles expected 0", stale);
      end
      run_single(32'hCAFEF00D, 5'd12, 2'b00, 1'b0, got, lat);
      checks++;
      if (lat != S || got !== 32'h00DCAFEF) begin
         failures++;
         $display("FAIL midrst_next: got %h after %0d cycles expected 00dcafef after %0d",
                  got, lat, S);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      out_ready = 1'b1;
      idle_inputs();
      test_reset();
      test_rotate();
      test_shift();
      test_back_to_back();
      test_sweep();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/barrel_shifter_pipe.md
BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 SHALL have parameter W, default 32, data width; legal values 8, 16, 32, 64.
REQ-002 SHALL have derived localparam S = log2(W), default 5, shift-amount width and stage count.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  input word present.
REQ-006 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-007 SHALL have port in_data  input  W  operand.
REQ-008 SHALL have port in_amt  input  S  shift/rotate amount, 0..W-1.
REQ-009 SHALL have port in_mode  input  2  00 ROR, 01 ROL, 10 SHR, 11 SHL.
REQ-010 SHALL have port in_arith  input  1  SHR fill select: 1 = sign fill, 0 = zero fill.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out_data  output  W  result.

Function
REQ-014 SHALL accept a word when in_valid && in_ready in the same cycle.
REQ-015 SHALL use S register stages; stage k applies a 2^k move when amt bit k is 1, else passes the data through unchanged.
REQ-016 SHALL carry each word's amt, mode and arith flag down the pipeline alongside its data.
REQ-017 SHALL present the result on out_valid exactly S cycles after acceptance, absent stalls.
REQ-018 SHALL rotate right (ROR) and left (ROL) with wrap-around; amt 0 returns in_data unchanged.
REQ-019 SHALL, for SHL, fill vacated LSBs with 0.
REQ-020 SHALL, for SHR, fill vacated MSBs with in_data[W-1] if in_arith=1, else 0.
REQ-021 SHALL keep ROR amt a and ROL amt W-a identical for every a.
REQ-022 SHALL stall globally: stall = out_valid && !out_ready; while stalled, no stage register changes.
REQ-023 SHALL drive in_ready = !stall, combinationally.
REQ-024 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-025 SHALL sustain one word per cycle with out_ready held high.
REQ-026 SHALL deliver results in acceptance order, with no loss or duplication.
REQ-027 SHALL let a bubble (stage valid=0) advance normally and never produce out_valid.
REQ-028 SHALL, when an input is accepted and an output taken in the same cycle, perform both.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, clear all stage valid bits, out_valid=0, out_data=0 and all stage data, amt and mode registers to 0.
REQ-030 SHALL discard in-flight words on reset mid-operation; out_valid=0 on the first cycle after the reset edge.
REQ-031 SHALL drive in_ready=1 during and after reset, since out_valid=0.

Configuration
REQ-032 SHALL support macro BARREL_SHIFTER_SRA_EN.
REQ-033 SHALL, when BARREL_SHIFTER_SRA_EN is defined, honour in_arith per REQ-020.
REQ-034 SHALL, when BARREL_SHIFTER_SRA_EN is undefined, ignore in_arith, zero-fill SHR, and omit the arith pipeline flops.

Structure
REQ-035 SHALL place the mode encodings (MODE_ROR, MODE_ROL, MODE_SHR, MODE_SHL) and the mode typedef in shared package barrel_pkg.
REQ-036 SHALL implement one stage as sub-module barrel_stage, parameters W and K (move = 2^K), instantiated S times via generate.
REQ-037 SHALL keep barrel_stage's data path combinational and its registers gated by the global stall enable.

Verification (W=32)
REQ-038 SHALL verify reset: rst high 3 cycles -> out_valid=0, out_data=0, in_ready=1.
REQ-039 SHALL verify rotates: ROR 0xFFFF0000 amt 4 -> 0x0FFFF000 at cycle +5; ROR amt 16 -> 0x0000FFFF; ROL 0x80000001 amt 1 -> 0x00000003.
REQ-040 SHALL verify SHR: 0x80000000 amt 31, in_arith=1 -> 0xFFFFFFFF with macro defined, 0x00000001 without; SHL 0x00000001 amt 31 -> 0x80000000.
REQ-041 SHALL verify backpressure: 8 back-to-back words with out_ready low for 3 cycles mid-stream -> in_ready low for those cycles, all 8 results in order, no duplicates.
REQ-042 SHALL verify a sweep: all 4 modes × amt 0..31 on random data, checked against a behavioural model, at full throughput.
REQ-043 SHALL verify reset mid-stream: 3 words in flight, rst pulsed -> no stale out_valid; next accepted word emerges correctly after 5 cycles.
